// File: rtl/axis_seg_pkg.sv
// rtl/axis_seg_pkg.sv - shared types and helpers for the segment demultiplexer
package axis_seg_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  // Widest segment count the nonzero-mask helpers support.
  localparam int MAX_SEG = 32;
  localparam int IDX_W   = 5;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wrap;
  } nz_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // First set bit at or above 'from'; if none, wrap=1 and idx is the lowest set bit.
  // With from=0, wrap=1 means the whole mask is empty.
  function automatic nz_t next_nonzero(input logic [MAX_SEG-1:0] nz, input int from);
    nz_t r;
    r.idx  = '0;
    r.wrap = 1'b1;
    for (int i = MAX_SEG - 1; i >= 0; i--) begin
      if (nz[i] && (i >= from)) begin
        r.idx  = IDX_W'(i);
        r.wrap = 1'b0;
      end
    end
    if (r.wrap) begin
      for (int i = MAX_SEG - 1; i >= 0; i--) begin
        if (nz[i]) r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_seg_demux_if.sv
// rtl/axis_seg_demux_if.sv - input stream plus fanned-out per-channel output streams
interface axis_seg_demux_if #(
  parameter int D_W     = 32,
  parameter int NUM_SEG = 9
);
  logic [D_W-1:0]     s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic               s_tlast;
  logic [D_W-1:0]     m_tdata;
  logic [NUM_SEG-1:0] m_tvalid;
  logic [NUM_SEG-1:0] m_tready;
  logic [NUM_SEG-1:0] m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/axis_seg_reg_slice.sv
// rtl/axis_seg_reg_slice.sv - single-entry output register carrying data, destination and last
module axis_seg_reg_slice #(
  parameter int D_W    = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D_W-1:0]    in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D_W-1:0]    out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [D_W-1:0]    data_q, data_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              last_q, last_d;

  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      dest_d  = in_dest;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_dest  = dest_q;
  assign out_last  = last_q;

endmodule

// File: rtl/axis_seg_demux.sv
// rtl/axis_seg_demux.sv - splits one stream into NUM_SEG ordered, length-programmed segments
module axis_seg_demux
  import axis_seg_pkg::*;
#(
  parameter int  D_W     = 32,
  parameter int  NUM_SEG = 9,
  parameter int  LEN_W   = 24,
  localparam int SEG_W   = (clog2(NUM_SEG) < 1) ? 1 : clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_SEG*LEN_W-1:0] cfg_len,
  axis_seg_demux_if.slave          bus,
  output logic [SEG_W-1:0]         seg_idx,
  output logic                     frame_done,
  output logic                     len_err
);

  state_e           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q [NUM_SEG];
  logic [LEN_W-1:0] len_d [NUM_SEG];
  logic             len_err_q, len_err_d;

  logic [MAX_SEG-1:0] cfg_nz, len_nz;
  nz_t                nn_cfg, nn_next;
  logic               idx_unused;

  logic               slice_ready, s_ready, accept, seg_end, frame_end;
  logic               out_v, out_last, out_ready;
  logic [SEG_W-1:0]   out_dest;
  logic [NUM_SEG-1:0] m_v, m_l;

  always_comb begin
    cfg_nz = '0;
    len_nz = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      cfg_nz[i] = |cfg_len[i*LEN_W +: LEN_W];
      len_nz[i] = |len_q[i];
    end
    nn_cfg  = next_nonzero(cfg_nz, 0);
    nn_next = next_nonzero(len_nz, int'(seg_q) + 1);
  end

  assign idx_unused = ^{nn_cfg.idx, nn_next.idx};

  assign s_ready   = (state_q == RUN) && slice_ready;
  assign accept    = bus.s_tvalid && s_ready;
  assign seg_end   = (cnt_q == len_q[seg_q] - LEN_W'(1));
  assign frame_end = seg_end && nn_next.wrap;

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !nn_cfg.wrap) begin
          for (int i = 0; i < NUM_SEG; i++) len_d[i] = cfg_len[i*LEN_W +: LEN_W];
          seg_d   = nn_cfg.idx[SEG_W-1:0];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (bus.s_tlast != frame_end) len_err_d = 1'b1;
          if (!seg_end) begin
            cnt_d = cnt_q + LEN_W'(1);
          end else begin
            cnt_d = '0;
            if (!nn_next.wrap) begin
              seg_d = nn_next.idx[SEG_W-1:0];
            end else begin
              frame_done = 1'b1;
              // Lengths are resampled only here, so mid-frame cfg edits wait for the next frame.
              if (en && !nn_cfg.wrap) begin
                for (int i = 0; i < NUM_SEG; i++) len_d[i] = cfg_len[i*LEN_W +: LEN_W];
                seg_d = nn_cfg.idx[SEG_W-1:0];
              end else begin
                seg_d   = '0;
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seg_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
      for (int i = 0; i < NUM_SEG; i++) len_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
      len_q     <= len_d;
    end
  end

  axis_seg_reg_slice #(
    .D_W    (D_W),
    .DEST_W (SEG_W)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_ready  (slice_ready),
    .in_data   (bus.s_tdata),
    .in_dest   (seg_q),
    .in_last   (seg_end),
    .out_valid (out_v),
    .out_ready (out_ready),
    .out_data  (bus.m_tdata),
    .out_dest  (out_dest),
    .out_last  (out_last)
  );

  always_comb begin
    m_v = '0;
    m_l = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      m_v[i] = out_v && (out_dest == SEG_W'(i));
      m_l[i] = m_v[i] && out_last;
    end
  end

  assign out_ready    = |(m_v & bus.m_tready);
  assign bus.m_tvalid = m_v;
  assign bus.m_tlast  = m_l;
  assign bus.s_tready = s_ready;
  assign seg_idx      = seg_q;
  assign len_err      = len_err_q;

endmodule
